horner_controle_param: RTL and testbench
========================================

// Module: horner_controle_param
// PURPOSE
//  - Parametrised successor to the fixed 8-state polynomial controller: evaluates y = sum a_i*x^i, i=0..DEGREE, by Horner's rule.
//  - Contains FSM control and the X/H/S register datapath; coefficients come from an external synchronous ROM.
//  - Sits between the host start/ready/valid handshake and the coefficient memory.
// PARAMETERS
//  - WIDTH   8  data width of x, coefficients, accumulator and y (unsigned, modulo 2^WIDTH)
//  - DEGREE  2  polynomial degree, >=0; DEGREE+1 coefficients
//  - AW      max(1,$clog2(DEGREE+1))  coefficient address width (localparam, derived)
// PORTS
//  - clock      in   1      single clock, rising edge
//  - reset      in   1      synchronous, active-high
//  - start      in   1      request; sampled only when ready=1
//  - x_in       in   WIDTH  evaluation point, captured on the accepted-start edge
//  - coef_addr  out  AW     coefficient ROM address (combinational from state/idx)
//  - coef_data  in   WIDTH  ROM data = a[coef_addr] of the PREVIOUS cycle (1-cycle read latency)
//  - ready      out  1      high only in IDLE
//  - valid      out  1      one-cycle pulse, y is new
//  - y          out  WIDTH  result register; holds last result until next DONE
//  - state      out  3      current FSM state, for debug/visibility
// BEHAVIOUR
//  - Reset (sync): state=IDLE, ready=1, valid=0, y=0, Reg_X=0, Reg_H=0, idx=0; also abandons any evaluation in progress.
//  - FSM states:
//    - IDLE: start=1 -> Reg_X<=x_in, idx<=DEGREE, go INIT; else stay.
//    - INIT: coef_addr=DEGREE; go LOAD_H.
//    - LOAD_H: Reg_H<=coef_data (a_DEGREE).
//      - DEGREE==0: Reg_S<=coef_data, go DONE.
//      - else: idx<=idx-1, go MUL.
//    - MUL: coef_addr=idx; Reg_H<=(Reg_H*Reg_X)[WIDTH-1:0]; go ADD.
//    - ADD: Reg_H<=Reg_H+coef_data (mod 2^WIDTH).
//      - idx==0: Reg_S<=sum, go DONE.
//      - else: idx<=idx-1, go MUL.
//    - DONE: valid=1 for this cycle only; go IDLE.
//  - Latency: start sampled at edge 0 -> valid high in the cycle after edge 2+2*DEGREE; accepted starts are 2*DEGREE+4 cycles apart minimum.
//  - coef_addr outside INIT/MUL: 0.
//  - start while ready=0: ignored, never queued; holding start high gives back-to-back evaluations.
//  - x_in changes after capture have no effect on the result.
//  - y (Reg_S) changes only on the edge entering DONE; stable otherwise.
//  - Reset asserted in the same cycle as start: reset wins.
// CONFIGURATION
//  - Macro HORNER_OVF_EN defined: adds port `ovf out 1`.
//    - ovf cleared on accepted start.
//    - ovf set sticky if any MUL high half (WIDTH MSBs of the 2*WIDTH product) is nonzero, or any ADD carries out.
//    - ovf is updated with y on entry to DONE, holds until next DONE; reset value 0.
//  - Undefined: ovf port absent; truncation silent; all other behaviour identical.
// STRUCTURE
//  - Package horner_pkg: state encodings IDLE=0, INIT=1, LOAD_H=2, MUL=3, ADD=4, DONE=5 (3-bit typedef); default WIDTH/DEGREE constants.
//  - Sub-module horner_datapath (Reg_X, Reg_H, Reg_S, multiplier, adder, operand muxes, optional ovf logic).
//  - Top holds FSM and idx counter; drives register enables and mux selects.
// TESTING
//  - Reset: assert reset 2 cycles -> ready=1, valid=0, y=0, state=IDLE, coef_addr=0.
//  - W=8, D=2, a={a2=3,a1=2,a0=1}, x=4, pulse start -> y=57; valid exactly once, 7 cycles after the start edge.
//  - Wrap: W=8, D=2, a={1,0,0}, x=20 -> y=144 (400 mod 256); with HORNER_OVF_EN ovf=1; with a={3,2,1}, x=4 ovf=0.
//  - start held high 30 cycles, D=2 -> valid every 8 cycles; start pulses while busy ignored, x_in change mid-run has no effect.
//  - Reset asserted during MUL -> next cycle state=IDLE, ready=1, y=0, no valid pulse; new start then yields correct result.
//  - D=0, a0=9, x=200 -> y=9, valid 3 cycles after start; D=2, x=0 -> y=a0=1.

Source files
------------

// File: rtl/horner_controle_param_pkg.sv
// Shared types and constants for the Horner polynomial evaluator.
// State encodings are fixed because they are visible on the state port.
package horner_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_DEGREE = 2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_INIT   = 3'd1,
      S_LOAD_H = 3'd2,
      S_MUL    = 3'd3,
      S_ADD    = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      H_HOLD = 2'd0,
      H_COEF = 2'd1,
      H_MUL  = 2'd2,
      H_ADD  = 2'd3
   } h_sel_t;

   // A degree-0 polynomial still needs a one-bit address.
   function automatic int addr_width(input int degree);
      return (degree < 1) ? 1 : $clog2(degree + 1);
   endfunction

endpackage

// File: rtl/horner_controle_param_if.sv
// Host handshake plus coefficient ROM port of the Horner evaluator.
// The master side is the host/ROM, the slave side is the evaluator.
interface horner_controle_param_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 2
);
   logic             start;
   logic [WIDTH-1:0] x_in;
   logic             ready;
   logic             valid;
   logic [WIDTH-1:0] y;
   logic [2:0]       state;
   logic [AW-1:0]    coef_addr;
   logic [WIDTH-1:0] coef_data;

   modport master (
      output start, x_in, coef_data,
      input  ready, valid, y, state, coef_addr
   );

   modport slave (
      input  start, x_in, coef_data,
      output ready, valid, y, state, coef_addr
   );
endinterface

// File: rtl/horner_controle_param_datapath.sv
// X/H/S registers with multiplier and adder for Horner evaluation.
// HORNER_OVF_EN adds sticky overflow tracking and the ovf_o output.
module horner_datapath
   import horner_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ld_x_i,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] coef_i,
   input  h_sel_t           h_sel_i,
   input  logic             s_ld_i,
   input  logic             s_from_coef_i,
   output logic [WIDTH-1:0] y_o
`ifdef HORNER_OVF_EN
   ,
   input  logic             ovf_clr_i,
   output logic             ovf_o
`endif
);

   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] h_q, h_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] prod_lo;
   logic [WIDTH-1:0] sum_lo;

`ifdef HORNER_OVF_EN
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     sum;
   logic               acc_q, acc_d;
   logic               ovf_q, ovf_d;

   assign prod    = {{WIDTH{1'b0}}, h_q} * {{WIDTH{1'b0}}, x_q};
   assign sum     = {1'b0, h_q} + {1'b0, coef_i};
   assign prod_lo = prod[WIDTH-1:0];
   assign sum_lo  = sum[WIDTH-1:0];

   // acc tracks the running evaluation; ovf_q is only published with y.
   always_comb begin
      acc_d = acc_q;
      if (ovf_clr_i) begin
         acc_d = 1'b0;
      end else if (h_sel_i == H_MUL && (|prod[2*WIDTH-1:WIDTH])) begin
         acc_d = 1'b1;
      end else if (h_sel_i == H_ADD && sum[WIDTH]) begin
         acc_d = 1'b1;
      end
      ovf_d = ovf_q;
      if (s_ld_i) begin
         ovf_d = acc_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign ovf_o = ovf_q;
`else
   assign prod_lo = h_q * x_q;
   assign sum_lo  = h_q + coef_i;
`endif

   always_comb begin
      x_d = ld_x_i ? x_i : x_q;
      h_d = h_q;
      unique case (h_sel_i)
         H_COEF:  h_d = coef_i;
         H_MUL:   h_d = prod_lo;
         H_ADD:   h_d = sum_lo;
         default: h_d = h_q;
      endcase
      s_d = s_q;
      if (s_ld_i) begin
         s_d = s_from_coef_i ? coef_i : sum_lo;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_q <= '0;
         h_q <= '0;
         s_q <= '0;
      end else begin
         x_q <= x_d;
         h_q <= h_d;
         s_q <= s_d;
      end
   end

   assign y_o = s_q;

endmodule

// File: rtl/horner_controle_param.sv
// Horner polynomial evaluator: FSM and coefficient index counter.
// Define HORNER_OVF_EN to add the sticky overflow output ovf_o.
//
// state  | meaning
// IDLE   | ready for start, x captured on accept
// INIT   | address a[DEGREE] into the ROM
// LOAD_H | H <= a[DEGREE]
// MUL    | H <= H*X, address a[idx]
// ADD    | H <= H + a[idx], last step also loads S
// DONE   | valid pulse, y holds the new result
module horner_controle_param
   import horner_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DEGREE = DEF_DEGREE
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   horner_controle_param_if.slave  bus
`ifdef HORNER_OVF_EN
   ,
   output logic                    ovf_o
`endif
);

   localparam int            AW      = addr_width(DEGREE);
   localparam logic [AW-1:0] IDX_TOP = AW'(DEGREE);

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          start_acc;
   h_sel_t        h_sel;
   logic          s_ld;
   logic          s_from_coef;
   logic [AW-1:0] addr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      start_acc   = 1'b0;
      h_sel       = H_HOLD;
      s_ld        = 1'b0;
      s_from_coef = 1'b0;
      addr        = '0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               start_acc = 1'b1;
               idx_d     = IDX_TOP;
               state_d   = S_INIT;
            end
         end
         S_INIT: begin
            addr    = IDX_TOP;
            state_d = S_LOAD_H;
         end
         S_LOAD_H: begin
            h_sel = H_COEF;
            // A constant polynomial is finished as soon as a0 arrives.
            if (DEGREE == 0) begin
               s_ld        = 1'b1;
               s_from_coef = 1'b1;
               state_d     = S_DONE;
            end else begin
               idx_d   = idx_q - AW'(1);
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            addr    = idx_q;
            h_sel   = H_MUL;
            state_d = S_ADD;
         end
         S_ADD: begin
            h_sel = H_ADD;
            if (idx_q == '0) begin
               s_ld    = 1'b1;
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q - AW'(1);
               state_d = S_MUL;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   horner_datapath #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .ld_x_i        (start_acc),
      .x_i           (bus.x_in),
      .coef_i        (bus.coef_data),
      .h_sel_i       (h_sel),
      .s_ld_i        (s_ld),
      .s_from_coef_i (s_from_coef),
      .y_o           (bus.y)
`ifdef HORNER_OVF_EN
      ,
      .ovf_clr_i     (start_acc),
      .ovf_o         (ovf_o)
`endif
   );

   assign bus.ready     = (state_q == S_IDLE);
   assign bus.valid     = (state_q == S_DONE);
   assign bus.state     = state_q;
   assign bus.coef_addr = addr;

endmodule

// File: tb/tb_horner_controle_param.sv
// Directed bench for horner_controle_param at DEGREE=2 and DEGREE=0,
// each instance fed by its own one-cycle-latency coefficient ROM.
module tb_horner_controle_param;
   import horner_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   horner_controle_param_if #(.WIDTH(8), .AW(2)) b2 ();
   horner_controle_param_if #(.WIDTH(8), .AW(1)) b0 ();

`ifdef HORNER_OVF_EN
   logic ovf2, ovf0;
`endif

   horner_controle_param #(.WIDTH(8), .DEGREE(2)) dut2 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (b2.slave)
`ifdef HORNER_OVF_EN
      ,
      .ovf_o (ovf2)
`endif
   );

   horner_controle_param #(.WIDTH(8), .DEGREE(0)) dut0 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (b0.slave)
`ifdef HORNER_OVF_EN
      ,
      .ovf_o (ovf0)
`endif
   );

   logic [7:0] rom2 [0:3];
   logic [7:0] rom0 [0:1];

   always @(posedge clk) begin
      b2.coef_data <= rom2[b2.coef_addr];
      b0.coef_data <= rom0[b0.coef_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_start(input int d, input logic v, input logic [7:0] xv);
      if (d == 2) begin
         b2.start = v;
         b2.x_in  = xv;
      end else begin
         b0.start = v;
         b0.x_in  = xv;
      end
   endtask

   function automatic logic [7:0] ydat(input int d);
      return (d == 2) ? b2.y : b0.y;
   endfunction
   function automatic logic vld(input int d);
      return (d == 2) ? b2.valid : b0.valid;
   endfunction
   function automatic logic rdy(input int d);
      return (d == 2) ? b2.ready : b0.ready;
   endfunction
   function automatic logic [2:0] st(input int d);
      return (d == 2) ? b2.state : b0.state;
   endfunction
   function automatic logic [1:0] adr(input int d);
      return (d == 2) ? b2.coef_addr : {1'b0, b0.coef_addr};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One evaluation: x changed after capture, extra start pulse while busy.
   task automatic run(input int d, input logic [7:0] xv, input logic [7:0] ey,
                      input logic eovf, input string tag);
      int         nval;
      int         lat;
      logic [7:0] yv;
      nval = 0;
      lat  = -1;
      yv   = '0;
      set_start(d, 1'b1, xv);
      tick();
      set_start(d, 1'b0, ~xv);
      chk({tag, "_init_state"}, 32'(st(d)), 32'(S_INIT));
      chk({tag, "_init_addr"}, 32'(adr(d)), 32'(d));
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (vld(d)) begin
            nval++;
            lat = k;
            yv  = ydat(d);
         end
         if (d == 2 && k == 2) set_start(d, 1'b1, xv + 8'd1);
         if (d == 2 && k == 3) set_start(d, 1'b0, ~xv);
      end
      chk({tag, "_valid_count"}, 32'(nval), 32'd1);
      chk({tag, "_latency"}, 32'(lat), 32'(2 * d + 2));
      chk({tag, "_y_at_valid"}, 32'(yv), 32'(ey));
      chk({tag, "_y_hold"}, 32'(ydat(d)), 32'(ey));
      chk({tag, "_ready_after"}, 32'(rdy(d)), 32'd1);
`ifdef HORNER_OVF_EN
      chk({tag, "_ovf"}, 32'((d == 2) ? ovf2 : ovf0), 32'(eovf));
`else
      if (eovf === 1'bx) $display("unexpected ovf argument in %s", tag);
`endif
   endtask

   initial begin
      int nval;
      int last;
      int gap_bad;

      rom2[0] = 8'd1; rom2[1] = 8'd2; rom2[2] = 8'd3; rom2[3] = 8'd0;
      rom0[0] = 8'd9; rom0[1] = 8'd0;
      set_start(2, 1'b0, 8'd0);
      set_start(0, 1'b0, 8'd0);
      b2.coef_data = '0;
      b0.coef_data = '0;

      rst = 1'b1;
      tick();
      tick();
      chk("rst_ready", 32'(b2.ready), 32'd1);
      chk("rst_valid", 32'(b2.valid), 32'd0);
      chk("rst_y", 32'(b2.y), 32'd0);
      chk("rst_state", 32'(b2.state), 32'(S_IDLE));
      chk("rst_addr", 32'(b2.coef_addr), 32'd0);
      chk("rst_y_d0", 32'(b0.y), 32'd0);
      rst = 1'b0;
      tick();

      // 3x^2 + 2x + 1 at x=4
      run(2, 8'd4, 8'd57, 1'b0, "poly_x4");

      // x^2 at x=20 wraps 400 -> 144
      rom2[0] = 8'd0; rom2[1] = 8'd0; rom2[2] = 8'd1;
      run(2, 8'd20, 8'd144, 1'b1, "wrap_x20");

      rom2[0] = 8'd1; rom2[1] = 8'd2; rom2[2] = 8'd3;
      run(2, 8'd0, 8'd1, 1'b0, "poly_x0");

      // start held high: back-to-back evaluations every 8 cycles
      nval    = 0;
      last    = -1;
      gap_bad = 0;
      set_start(2, 1'b1, 8'd4);
      for (int k = 0; k < 30; k++) begin
         tick();
         if (b2.valid) begin
            nval++;
            chk("held_y", 32'(b2.y), 32'd57);
            if (last >= 0 && (k - last) != 8) gap_bad++;
            last = k;
         end
      end
      set_start(2, 1'b0, 8'd0);
      chk("held_valid_count", 32'(nval), 32'd3);
      chk("held_gap_errors", 32'(gap_bad), 32'd0);
      for (int i = 0; i < 20 && !b2.ready; i++) tick();
      chk("held_drain_ready", 32'(b2.ready), 32'd1);
      tick();

      // reset while in MUL abandons the evaluation
      set_start(2, 1'b1, 8'd4);
      tick();
      set_start(2, 1'b0, 8'd0);
      tick();
      tick();
      chk("mid_state_mul", 32'(b2.state), 32'(S_MUL));
      rst = 1'b1;
      tick();
      chk("mid_rst_state", 32'(b2.state), 32'(S_IDLE));
      chk("mid_rst_ready", 32'(b2.ready), 32'd1);
      chk("mid_rst_y", 32'(b2.y), 32'd0);
      chk("mid_rst_valid", 32'(b2.valid), 32'd0);
      rst  = 1'b0;
      nval = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (b2.valid) nval++;
      end
      chk("mid_no_valid", 32'(nval), 32'd0);
      run(2, 8'd4, 8'd57, 1'b0, "after_rst");

      // constant polynomial, DEGREE=0
      run(0, 8'd200, 8'd9, 1'b0, "deg0");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
